// File: rtl/bus_dmem_if.sv
// bus_dmem_if: CPU data-bus connection between the memory-stage master and the data memory slave.
interface bus_dmem_if;
  logic [31:0] b_addr_i;
  logic [31:0] b_data_i;
  logic        b_read_i;
  logic        b_write_i;
  logic [31:0] b_data_o;
  logic        b_ack_o;
  logic        b_err_o;
  modport master (output b_addr_i, b_data_i, b_read_i, b_write_i, input b_data_o, b_ack_o, b_err_o);
  modport slave  (input b_addr_i, b_data_i, b_read_i, b_write_i, output b_data_o, b_ack_o, b_err_o);
endinterface

// File: rtl/bus_dmem.sv
// bus_dmem: single-port word data memory bus slave with configurable wait states and out-of-window error.
module bus_dmem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input logic       clk,
  input logic       rst_n,
  bus_dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIM = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [31:0]   r_addr, r_wdata, r_data;
  logic          r_write, r_ack, r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          w_idle, w_req, w_go_ack, w_wr, w_in, w_we;
  logic [31:0]   w_addr, w_wdata, w_off;
  logic [AW-1:0] w_idx;
  // With zero wait states IDLE goes straight to ACK, so the live inputs are used on that edge.
  always_comb begin
    w_idle   = r_state == S_IDLE;
    w_req    = bus.b_read_i | bus.b_write_i;
    w_addr   = w_idle ? bus.b_addr_i : r_addr;
    w_wdata  = w_idle ? bus.b_data_i : r_wdata;
    w_wr     = w_idle ? bus.b_write_i : r_write;
    w_go_ack = (w_idle && w_req && WAIT_STATES == 0) || (r_state == S_WAIT && r_cnt == 4'd1);
    w_in     = {1'b0, w_addr} >= {1'b0, BASE_ADDR} && {1'b0, w_addr} < LIM;
    w_off    = w_addr - BASE_ADDR;
    w_idx    = AW'(w_off >> 2);
    w_we     = rst_n && w_go_ack && w_wr && w_in;
  end
  always_ff @(posedge clk)
    if (w_we) r_mem[w_idx] <= w_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (w_go_ack) begin
        r_state <= S_ACK;
        r_ack   <= 1'b1;
        r_err   <= !w_in;
        if (!w_wr) r_data <= w_in ? r_mem[w_idx] : ERR_DATA;
      end
      case (r_state)
        S_IDLE: if (w_req) begin
          r_addr  <= bus.b_addr_i;
          r_wdata <= bus.b_data_i;
          r_write <= bus.b_write_i;
          r_cnt   <= 4'(WAIT_STATES);
          if (WAIT_STATES != 0) r_state <= S_WAIT;
        end
        S_WAIT: r_cnt <= r_cnt - 4'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  assign bus.b_data_o = r_data;
  assign bus.b_ack_o  = r_ack;
  assign bus.b_err_o  = r_err;
endmodule

// File: tb/tb_bus_dmem.sv
// tb_bus_dmem: directed bus transfers with a queue scoreboard checked by an independent ack monitor.
module tb_bus_dmem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] last_rd = '0;
  typedef struct {logic [31:0] d; logic e;} exp_t;
  exp_t sb_q[$];
  bus_dmem_if bus ();
  bus_dmem #(.WAIT_STATES(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rst_n && bus.b_ack_o) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ack data=%h err=%b", bus.b_data_o, bus.b_err_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        total++;
        if (bus.b_data_o !== e.d || bus.b_err_o !== e.e) begin
          bad++;
          $display("FAIL ack_resp got data=%h err=%b want data=%h err=%b", bus.b_data_o, bus.b_err_o, e.d, e.e);
        end
      end
    end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic exp_e);
    int cyc;
    sb_q.push_back('{exp_d, exp_e});
    @(posedge clk); #1;
    bus.b_addr_i = a; bus.b_data_i = d; bus.b_read_i = rd; bus.b_write_i = wr;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.b_ack_o || cyc >= 20) break;
      cyc++;
    end
    bus.b_read_i = 1'b0; bus.b_write_i = 1'b0;
    chk("latency", 32'(cyc), 32'd2);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic e);
    xfer(1'b0, 1'b1, a, d, last_rd, e);
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic e);
    xfer(1'b1, 1'b0, a, 32'h0, d, e);
    last_rd = d;
  endtask
  initial begin
    bus.b_addr_i = '0; bus.b_data_i = '0; bus.b_read_i = 1'b0; bus.b_write_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ack", 32'(bus.b_ack_o), 32'd0);
      chk("idle_err", 32'(bus.b_err_o), 32'd0);
      chk("idle_data", bus.b_data_o, 32'd0);
    end
    wr(32'h10, 32'h1234_5678, 1'b0);
    rd(32'h10, 32'h1234_5678, 1'b0);
    rd(32'h13, 32'h1234_5678, 1'b0);
    wr(32'h0, 32'h0BAD_F00D, 1'b0);
    wr(32'h3FFC, 32'hCAFE_0001, 1'b0);
    wr(32'h4000, 32'h1111_1111, 1'b1);
    rd(32'h4000, 32'hDEAD_BEEF, 1'b1);
    rd(32'h0, 32'h0BAD_F00D, 1'b0);
    rd(32'h3FFC, 32'hCAFE_0001, 1'b0);
    rd(32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1);
    xfer(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, last_rd, 1'b0);
    rd(32'h20, 32'hA5A5_A5A5, 1'b0);
    wr(32'h30, 32'h0, 1'b0);
    @(posedge clk); #1;
    bus.b_addr_i = 32'h30; bus.b_data_i = 32'hFFFF_FFFF; bus.b_write_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.b_write_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ack", 32'(bus.b_ack_o), 32'd0);
    end
    rst_n = 1'b1;
    last_rd = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_ack", 32'(bus.b_ack_o), 32'd0);
    end
    chk("post_rst_data", bus.b_data_o, 32'd0);
    rd(32'h30, 32'h0, 1'b0);
    rd(32'h10, 32'h1234_5678, 1'b0);
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
